// File: rtl/drp_reg_responder.sv
// DRP target exposing REG_COUNT 16-bit soft registers with a fixed response latency.
// Optional error counter port err_count is enabled by defining DRP_REG_RESPONDER_ERR_CNT_EN.
module drp_reg_responder #(
   parameter int          ADDR_WIDTH  = 10,
   parameter int          REG_COUNT   = 8,
   parameter int          RDY_LATENCY = 2,
   parameter logic [15:0] RESET_VAL   = 16'h0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH-1:0]     drp_addr,
   input  logic [15:0]               drp_di,
   output logic [15:0]               drp_do,
   input  logic                      drp_en,
   input  logic                      drp_we,
   output logic                      drp_rdy,
   output logic [REG_COUNT*16-1:0]   reg_out,
   output logic [REG_COUNT-1:0]      reg_wr_stb
`ifdef DRP_REG_RESPONDER_ERR_CNT_EN
   ,
   output logic [15:0]               err_count
`endif
);

   localparam int         IDX_W  = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
   localparam logic [3:0] LAT_M1 = 4'(RDY_LATENCY - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]            r_state;
   logic [3:0]            r_cnt;
   logic                  r_rdy;
   logic [15:0]           r_do;
   logic [REG_COUNT-1:0]  r_stb;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [15:0]           r_di;
   logic                  r_we;
   logic [15:0]           r_regs [REG_COUNT];

   logic                  w_accept;
   logic                  w_fire_now;
   logic                  w_fire_busy;
   logic                  w_fire;
   logic [ADDR_WIDTH-1:0] w_f_addr;
   logic [15:0]           w_f_di;
   logic                  w_f_we;
   logic                  w_hit;
   logic [IDX_W-1:0]      w_idx;
   logic [15:0]           w_rd_data;
   logic [REG_COUNT-1:0]  w_stb;

   // With unit latency the response is produced straight from the request inputs.
   assign w_accept    = (r_state == S_IDLE) && drp_en;
   assign w_fire_now  = w_accept && (LAT_M1 == 4'd0);
   assign w_fire_busy = (r_state == S_BUSY) && (r_cnt == 4'd1);
   assign w_fire      = w_fire_now || w_fire_busy;

   assign w_f_addr = w_fire_now ? drp_addr : r_addr;
   assign w_f_di   = w_fire_now ? drp_di   : r_di;
   assign w_f_we   = w_fire_now ? drp_we   : r_we;

   // Full-width compare so upper address bits never alias onto a register.
   assign w_hit = (32'(w_f_addr) < 32'(REG_COUNT));
   assign w_idx = w_f_addr[IDX_W-1:0];

   always_comb begin
      w_rd_data = 16'h0000;
      w_stb     = '0;
      if (w_hit) begin
         w_rd_data = r_regs[w_idx];
         if (w_fire && w_f_we) begin
            w_stb[w_idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_rdy   <= 1'b0;
         r_do    <= 16'h0000;
         r_stb   <= '0;
      end else begin
         r_rdy <= w_fire;
         r_do  <= (w_fire && !w_f_we) ? w_rd_data : 16'h0000;
         r_stb <= w_stb;
         case (r_state)
            S_IDLE: begin
               if (drp_en && (LAT_M1 != 4'd0)) begin
                  r_state <= S_BUSY;
                  r_cnt   <= LAT_M1;
               end
            end
            S_BUSY: begin
               if (r_cnt == 4'd1) begin
                  r_state <= S_IDLE;
                  r_cnt   <= 4'd0;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= 4'd0;
            end
         endcase
      end
   end

   // Request fields are only meaningful once accepted, so they carry no reset.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_addr <= drp_addr;
         r_di   <= drp_di;
         r_we   <= drp_we;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < REG_COUNT; i++) begin
         if (rst) begin
            r_regs[i] <= RESET_VAL;
         end else if (w_stb[i]) begin
            r_regs[i] <= w_f_di;
         end
      end
   end

   genvar g;
   generate
      for (g = 0; g < REG_COUNT; g++) begin : g_out
         assign reg_out[g*16 +: 16] = r_regs[g];
      end
   endgenerate

   assign drp_rdy    = r_rdy;
   assign drp_do     = r_do;
   assign reg_wr_stb = r_stb;

`ifdef DRP_REG_RESPONDER_ERR_CNT_EN
   logic [15:0] r_err;
   logic        w_ign;
   logic        w_oor;

   // A dropped request and an out-of-range response in the same cycle count once.
   assign w_ign = (r_state == S_BUSY) && drp_en;
   assign w_oor = w_fire && !w_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 16'h0000;
      end else if ((w_ign || w_oor) && (r_err != 16'hFFFF)) begin
         r_err <= r_err + 16'h0001;
      end
   end

   assign err_count = r_err;
`endif

endmodule

// File: tb/tb_drp_reg_responder.sv
// Bench for drp_reg_responder: two instances (latency 2 and 1) share one stimulus stream
// and are compared every cycle against a transaction-level register model.
module tb_drp_reg_responder;

   localparam int          AW = 10;
   localparam int          RC = 8;
   localparam logic [15:0] RV = 16'h0000;

   logic                      clk = 1'b0;
   logic                      rst;
   logic [AW-1:0]             addr;
   logic [15:0]               di;
   logic                      en;
   logic                      we;
   logic [1:0][15:0]          dout;
   logic [1:0]                rdy;
   logic [1:0][RC*16-1:0]     ro;
   logic [1:0][RC-1:0]        stb;
`ifdef DRP_REG_RESPONDER_ERR_CNT_EN
   logic [1:0][15:0]          errc;
   logic [15:0]               eerr [2];
`endif

   always #5 clk = ~clk;

   drp_reg_responder #(.ADDR_WIDTH(AW), .REG_COUNT(RC), .RDY_LATENCY(2), .RESET_VAL(RV)) dut_l2 (
      .clk(clk), .rst(rst), .drp_addr(addr), .drp_di(di), .drp_do(dout[0]), .drp_en(en),
      .drp_we(we), .drp_rdy(rdy[0]), .reg_out(ro[0]), .reg_wr_stb(stb[0])
`ifdef DRP_REG_RESPONDER_ERR_CNT_EN
      , .err_count(errc[0])
`endif
   );

   drp_reg_responder #(.ADDR_WIDTH(AW), .REG_COUNT(RC), .RDY_LATENCY(1), .RESET_VAL(RV)) dut_l1 (
      .clk(clk), .rst(rst), .drp_addr(addr), .drp_di(di), .drp_do(dout[1]), .drp_en(en),
      .drp_we(we), .drp_rdy(rdy[1]), .reg_out(ro[1]), .reg_wr_stb(stb[1])
`ifdef DRP_REG_RESPONDER_ERR_CNT_EN
      , .err_count(errc[1])
`endif
   );

   int            checks = 0;
   int            failures = 0;
   int            cyc = 0;
   logic [15:0]   mem [2][RC];
   int            nfree [2];
   bit            pv [2];
   int            pc [2];
   bit            pwe [2];
   int            pa [2];
   logic [15:0]   pd [2];

   function automatic int lat(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   task automatic chk(input string tag, input int k, input logic [RC*16-1:0] obs,
                      input logic [RC*16-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s lat%0d cycle %0d: observed %h expected %h", tag, lat(k), cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < RC; i++) mem[k][i] = RV;
         pv[k]    = 1'b0;
         nfree[k] = 0;
`ifdef DRP_REG_RESPONDER_ERR_CNT_EN
         eerr[k]  = 16'h0000;
`endif
      end
   endtask

   // One clock cycle: drive inputs, check outputs at the falling edge, update the model.
   task automatic step(input bit r, input bit e, input bit w, input logic [AW-1:0] a,
                       input logic [15:0] d);
      bit                  acc [2];
      bit                  ign [2];
      logic                exp_rdy;
      logic [15:0]         exp_do;
      logic [RC-1:0]       exp_stb;
      logic [RC*16-1:0]    exp_ro;
      rst = r; en = e; we = w; addr = a; di = d;
      for (int k = 0; k < 2; k++) begin
         acc[k] = !r && e && (cyc >= nfree[k]);
         ign[k] = !r && e && !acc[k];
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         exp_rdy = 1'b0;
         exp_do  = 16'h0000;
         exp_stb = '0;
         if (pv[k] && pc[k] == cyc) begin
            exp_rdy = 1'b1;
            if (pa[k] < RC) begin
               if (pwe[k]) begin
                  mem[k][pa[k]] = pd[k];
                  exp_stb[pa[k]] = 1'b1;
               end else begin
                  exp_do = mem[k][pa[k]];
               end
            end
            pv[k] = 1'b0;
         end
         for (int i = 0; i < RC; i++) exp_ro[i*16 +: 16] = mem[k][i];
         chk("drp_rdy", k, {{(RC*16-1){1'b0}}, rdy[k]}, {{(RC*16-1){1'b0}}, exp_rdy});
         chk("drp_do", k, {{(RC*16-16){1'b0}}, dout[k]}, {{(RC*16-16){1'b0}}, exp_do});
         chk("reg_wr_stb", k, {{(RC*16-RC){1'b0}}, stb[k]}, {{(RC*16-RC){1'b0}}, exp_stb});
         chk("reg_out", k, ro[k], exp_ro);
`ifdef DRP_REG_RESPONDER_ERR_CNT_EN
         chk("err_count", k, {{(RC*16-16){1'b0}}, errc[k]}, {{(RC*16-16){1'b0}}, eerr[k]});
`endif
         if (acc[k]) begin
            pv[k]    = 1'b1;
            pc[k]    = cyc + lat(k);
            pwe[k]   = w;
            pa[k]    = int'(a);
            pd[k]    = d;
            nfree[k] = cyc + lat(k);
         end
`ifdef DRP_REG_RESPONDER_ERR_CNT_EN
         if ((ign[k] || (pv[k] && pc[k] == cyc + 1 && pa[k] >= RC)) && eerr[k] != 16'hFFFF)
            eerr[k] = eerr[k] + 16'h0001;
`endif
      end
      if (r) model_reset();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, '0, 16'h0000);
   endtask

   initial begin
      logic [AW-1:0] ra;
      rst = 1'b1; en = 1'b0; we = 1'b0; addr = '0; di = 16'h0000;
      model_reset();
      repeat (3) @(posedge clk);
      #1;

      // Read of a reset register.
      step(1'b0, 1'b1, 1'b0, 10'd3, 16'h0000);
      idle(3);

      // Write then read back the same register.
      step(1'b0, 1'b1, 1'b1, 10'd5, 16'hA5C3);
      idle(3);
      step(1'b0, 1'b1, 1'b0, 10'd5, 16'h0000);
      idle(3);

      // Out-of-range write and read, plus aliasing checks on upper address bits.
      step(1'b0, 1'b1, 1'b1, 10'd9, 16'h1234);
      idle(3);
      step(1'b0, 1'b1, 1'b0, 10'd9, 16'h0000);
      idle(3);
      step(1'b0, 1'b1, 1'b1, 10'd8, 16'h5555);
      idle(3);
      step(1'b0, 1'b1, 1'b1, 10'h205, 16'h6666);
      idle(3);
      step(1'b0, 1'b1, 1'b1, 10'd7, 16'hFFFF);
      idle(3);

      // Request while busy, then a request in the response cycle.
      step(1'b0, 1'b1, 1'b0, 10'd5, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 10'd7, 16'h0000);
      step(1'b0, 1'b1, 1'b0, 10'd7, 16'h0000);
      idle(3);

      // Reset right after a write was accepted.
      step(1'b0, 1'b1, 1'b1, 10'd2, 16'hBEEF);
      step(1'b1, 1'b0, 1'b0, 10'd0, 16'h0000);
      idle(3);
      step(1'b0, 1'b1, 1'b0, 10'd2, 16'h0000);
      idle(3);

      // Back-to-back write then read of register 0.
      step(1'b0, 1'b1, 1'b1, 10'd0, 16'h0001);
      step(1'b0, 1'b1, 1'b0, 10'd0, 16'h0000);
      idle(3);

      // Randomised traffic.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 9) == 0) ra = AW'($urandom);
         else ra = AW'($urandom_range(0, RC + 1));
         step(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0), 1'($urandom),
              ra, 16'($urandom));
      end
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
